dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the slave end of the CPU data port (byte write enables, word
//  address, write data, read data). Holds a word-organised RAM and answers each request
//  after a programmable number of wait states. Drives a stall back to the pipeline while
//  a request is outstanding. Sits between the CPU top and the SoC bus as the on-chip data RAM.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words; power of two
//  LATENCY  2     wait cycles from acceptance to resp_valid, range 1..15
// PORTS
//  clk         in   1   clock; everything on rising edge
//  rst         in   1   reset, asynchronous, active-high
//  req_en      in   1   request present (load or store)
//  req_wen     in   4   byte write enables; 4'b0000 = read
//  req_size    in   2   0 byte, 1 half, 2 word (alignment check only)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, lanes already positioned
//  req_ready   out  1   responder can accept (IDLE state)
//  resp_valid  out  1   one-cycle pulse: request completed
//  resp_rdata  out  32  read word, valid with resp_valid; whole word, CPU extends
//  stall       out  1   hold pipeline; request pending and not yet answered
//  addr_err    out  1   misaligned request flag, pulses with resp_valid (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, resp_valid 0, resp_rdata 0, addr_err 0. RAM not cleared.
//  - Word index = req_addr[log2(DEPTH)+1:2]; higher bits ignored (aliasing); addr[1:0] ignored for index.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: req_ready=1. On req_en: latch addr/wen; commit write lanes at this edge
//      (lane i written iff req_wen[i]); load counter with LATENCY-1; go BUSY.
//    BUSY: req_ready=0; decrement counter; at counter==0 register RAM[word] into resp_rdata, go RESP.
//    RESP: resp_valid=1 for exactly one cycle; req_ready=0; go IDLE unconditionally.
//  - Latency: req accepted at edge N -> resp_valid high during cycle after edge N+LATENCY.
//    Throughput one request per LATENCY+2 cycles; no back-to-back acceptance.
//  - stall = (state==IDLE & req_en) | state==BUSY. Low during RESP so the pipeline advances that cycle.
//  - Stores also pulse resp_valid; resp_rdata then shows the post-write word.
//  - Read after write to the same word always returns the new data (write commits at acceptance).
//  - req_* changing while BUSY/RESP is ignored. req_en held high after RESP is a new request.
//  - Reset mid-operation: FSM returns to IDLE at once, no resp_valid. A write already accepted stays in RAM.
// CONFIGURATION
//  DMEM_ADDR_ERR_EN defined: misaligned when size 1 & addr[0], or size 2 & addr[1:0]!=0.
//    Misaligned stores write no lanes. addr_err=1 with that request's resp_valid. Timing unchanged.
//  Not defined: no check; addr_err tied 0; all stores commit per req_wen.
// STRUCTURE
//  Shared package/header: state encodings (ST_IDLE, ST_BUSY, ST_RESP), size codes
//  (SZ_BYTE, SZ_HALF, SZ_WORD). Sub-module dmem_ram_bank: DEPTH x 32 array,
//  4 byte-lane write enables, synchronous read port. FSM and counter stay in top.
// TESTING
//  1 Reset: rst pulse mid-BUSY -> state IDLE, resp_valid/stall/addr_err 0, req_ready 1 next cycle.
//  2 Word store/load: wen=4'hF addr 0x10 wdata 0xDEADBEEF, then read 0x10 ->
//    resp_rdata=0xDEADBEEF exactly LATENCY+1 cycles after acceptance; stall high until that cycle.
//  3 Byte lanes: word 0x11223344 at 0x20, store wen=4'b0100 wdata 0x00AA0000 -> read gives 0x11AA3344.
//  4 Aliasing: store 0x5A5A5A5A at 0x0, read at DEPTH*4 -> 0x5A5A5A5A.
//  5 Misaligned (macro on): size=2 addr 0x22 wen 4'hF -> addr_err=1 with resp_valid, word unchanged;
//    macro off -> addr_err 0, write lands.
//  6 LATENCY=1 and 15: each request's resp_valid spacing = LATENCY+2 with req_en held high.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, access size codes
// and the alignment helper used when DMEM_ADDR_ERR_EN is defined.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SZ_HALF) && addr_lo[0]) ||
             ((size == SZ_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// DEPTH x 32 word RAM with per-byte write enables and a registered read port.
// Array contents are never reset; only the read register is.
module dmem_ram_bank #(
   parameter int DEPTH = 1024
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [3:0]               i_wen,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [31:0]              i_wdata,
   input  logic                     i_ren,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [31:0]              o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_wen[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)      r_rdata <= 32'd0;
      else if (i_ren) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// CPU data-port slave: accepts one request, waits LATENCY cycles, pulses resp_valid.
// Define DMEM_ADDR_ERR_EN to flag and suppress misaligned accesses.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | ready; a request is accepted and its store committed
//   ST_BUSY | counting down wait states; read issued at count 0
//   ST_RESP | resp_valid / addr_err high for this single cycle
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_en,
   input  logic [3:0]  i_req_wen,
   input  logic [1:0]  i_req_size,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_req_ready,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_stall,
   output logic        o_addr_err
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

   state_t          r_state;
   logic [3:0]      r_cnt;
   logic [AW-1:0]   r_word;
   logic            r_mis;
   logic            r_resp_valid;
   logic            r_addr_err;

   logic            w_accept;
   logic            w_mis;
   logic [AW-1:0]   w_idx;
   logic [3:0]      w_wen;
   logic            w_ren;
   logic            w_unused;

   assign w_accept = (r_state == ST_IDLE) && i_req_en;
   assign w_idx    = i_req_addr[AW+1:2];

`ifdef DMEM_ADDR_ERR_EN
   assign w_mis = f_misaligned(i_req_size, i_req_addr[1:0]);
`else
   assign w_mis = 1'b0;
`endif

   // Upper address bits alias; size only matters to the alignment check.
   assign w_unused = ^{i_req_size, i_req_addr[31:AW+2], i_req_addr[1:0]};

   // Store commits on the acceptance edge so a later read always sees it.
   assign w_wen = (w_accept && !w_mis) ? i_req_wen : 4'b0000;
   assign w_ren = (r_state == ST_BUSY) && (r_cnt == 4'd0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_word       <= '0;
         r_mis        <= 1'b0;
         r_resp_valid <= 1'b0;
         r_addr_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_req_en) begin
                  r_word  <= w_idx;
                  r_mis   <= w_mis;
                  r_cnt   <= LOAD_VAL;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_resp_valid <= 1'b1;
                  r_addr_err   <= r_mis;
                  r_state      <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_resp_valid <= 1'b0;
               r_addr_err   <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_resp_valid <= 1'b0;
               r_addr_err   <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   dmem_ram_bank #(.DEPTH(DEPTH)) u_ram (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wen   (w_wen),
      .i_waddr (w_idx),
      .i_wdata (i_req_wdata),
      .i_ren   (w_ren),
      .i_raddr (r_word),
      .o_rdata (o_resp_rdata)
   );

   assign o_req_ready  = (r_state == ST_IDLE);
   assign o_stall      = w_accept || (r_state == ST_BUSY);
   assign o_resp_valid = r_resp_valid;
   assign o_addr_err   = r_addr_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY 2 main instance, plus 1 and 15
// instances for throughput). Expectations follow DMEM_ADDR_ERR_EN when defined.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_en = 1'b0;
   logic [3:0]  req_wen = 4'h0;
   logic [1:0]  req_size = SZ_WORD;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_ready, resp_valid, stall, addr_err;
   logic [31:0] resp_rdata;

   logic        a_en = 1'b0;
   logic        a1_ready, a1_valid, a1_stall, a1_err;
   logic [31:0] a1_rdata;
   logic        a15_ready, a15_valid, a15_stall, a15_err;
   logic [31:0] a15_rdata;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;
   exp_t sb[$];
   logic [31:0] mem_m [DEPTH];
   int t1[$];
   int t15[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_en(req_en), .i_req_wen(req_wen),
      .i_req_size(req_size), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
      .o_stall(stall), .o_addr_err(addr_err));

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
      .i_clk(clk), .i_rst(rst), .i_req_en(a_en), .i_req_wen(4'h0),
      .i_req_size(SZ_WORD), .i_req_addr(32'h0), .i_req_wdata(32'h0),
      .o_req_ready(a1_ready), .o_resp_valid(a1_valid), .o_resp_rdata(a1_rdata),
      .o_stall(a1_stall), .o_addr_err(a1_err));

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut_l15 (
      .i_clk(clk), .i_rst(rst), .i_req_en(a_en), .i_req_wen(4'h0),
      .i_req_size(SZ_WORD), .i_req_addr(32'h0), .i_req_wdata(32'h0),
      .o_req_ready(a15_ready), .o_resp_valid(a15_valid), .o_resp_rdata(a15_rdata),
      .o_stall(a15_stall), .o_addr_err(a15_err));

   // Scoreboard monitor for the main instance.
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding");
         end else begin
            exp_t x;
            x = sb.pop_front();
            if (resp_rdata !== x.d) begin
               n_fail++;
               $display("FAIL resp_rdata: got %h expected %h", resp_rdata, x.d);
            end
            n_cmp++;
            if (addr_err !== x.e) begin
               n_fail++;
               $display("FAIL addr_err: got %b expected %b", addr_err, x.e);
            end
         end
      end
      if (!rst && a1_valid)  t1.push_back(cyc);
      if (!rst && a15_valid) t15.push_back(cyc);
   end

   task automatic model_apply(input logic [3:0] wen, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output exp_t x);
      logic [9:0] idx;
      logic       mis;
      idx = addr[11:2];
`ifdef DMEM_ADDR_ERR_EN
      mis = ((sz == SZ_HALF) && addr[0]) || ((sz == SZ_WORD) && (addr[1:0] != 2'b00));
`else
      mis = 1'b0;
`endif
      if (!mis) begin
         for (int i = 0; i < 4; i++)
            if (wen[i]) mem_m[idx][8*i +: 8] = wd[8*i +: 8];
      end
      x.d = mem_m[idx];
      x.e = mis;
   endtask

   task automatic issue(input logic [3:0] wen, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
      exp_t x;
      int   lat;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_before_req: got %b expected 1", req_ready);
      end
      req_en = 1'b1; req_wen = wen; req_size = sz; req_addr = addr; req_wdata = wd;
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_on_req: got %b expected 1", stall);
      end
      model_apply(wen, sz, addr, wd, x);
      sb.push_back(x);
      @(posedge clk); #1;
      req_en = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) begin
            lat = k;
            break;
         end
         n_cmp++;
         if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_busy: cycle %0d got %b expected 1", k, stall);
         end
      end
      n_cmp++;
      if (lat != LAT) begin
         n_fail++;
         $display("FAIL latency: got %0d expected %0d (0 = timeout)", lat, LAT);
      end
      n_cmp++;
      if (stall !== 1'b0 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL resp_cycle: stall=%b ready=%b expected 0/0", stall, req_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL back_to_idle: valid=%b ready=%b expected 0/1", resp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      exp_t x;
      #2;
      n_cmp++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || addr_err !== 1'b0 ||
          req_ready !== 1'b1 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b rdata=%h err=%b ready=%b stall=%b expected 0/0/0/1/0",
                  resp_valid, resp_rdata, addr_err, req_ready, stall);
      end
      @(negedge clk); rst = 1'b0;
      // Store accepted, then reset while BUSY: no response, but the write persists.
      @(negedge clk);
      req_en = 1'b1; req_wen = 4'hF; req_size = SZ_WORD; req_addr = 32'h40; req_wdata = 32'h12345678;
      model_apply(4'hF, SZ_WORD, 32'h40, 32'h12345678, x);
      @(posedge clk); #1;
      req_en = 1'b0;
      n_cmp++;
      if (stall !== 1'b1 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_before_reset: stall=%b ready=%b expected 1/0", stall, req_ready);
      end
      rst = 1'b1; #1;
      n_cmp++;
      if (resp_valid !== 1'b0 || stall !== 1'b0 || addr_err !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_busy: valid=%b stall=%b err=%b ready=%b expected 0/0/0/1",
                  resp_valid, stall, addr_err, req_ready);
      end
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: valid=%b ready=%b expected 0/1", resp_valid, req_ready);
         end
      end
      issue(4'h0, SZ_WORD, 32'h40, 32'h0);
   endtask

   task automatic test_word();
      issue(4'hF, SZ_WORD, 32'h10, 32'hDEADBEEF);
      issue(4'h0, SZ_WORD, 32'h10, 32'h0);
   endtask

   task automatic test_byte_lanes();
      issue(4'hF, SZ_WORD, 32'h20, 32'h11223344);
      issue(4'b0100, SZ_BYTE, 32'h22, 32'h00AA0000);
      issue(4'h0, SZ_WORD, 32'h20, 32'h0);
      issue(4'b0011, SZ_HALF, 32'h20, 32'hFFFF7788);
      issue(4'h0, SZ_WORD, 32'h20, 32'h0);
   endtask

   task automatic test_alias();
      issue(4'hF, SZ_WORD, 32'h0, 32'h5A5A5A5A);
      issue(4'h0, SZ_WORD, DEPTH * 4, 32'h0);
      issue(4'h0, SZ_WORD, 32'hFFFF_F000, 32'h0);
   endtask

   task automatic test_misaligned();
      issue(4'hF, SZ_WORD, 32'h24, 32'hCAFEF00D);
      issue(4'hF, SZ_WORD, 32'h22, 32'hFFFFFFFF);
      issue(4'h0, SZ_WORD, 32'h20, 32'h0);
      issue(4'b0011, SZ_HALF, 32'h25, 32'h0000ABCD);
      issue(4'h0, SZ_WORD, 32'h24, 32'h0);
   endtask

   task automatic test_back_to_back();
      int guard;
      @(negedge clk);
      a_en = 1'b1;
      guard = 0;
      while ((t1.size() < 3 || t15.size() < 3) && guard < 300) begin
         @(posedge clk);
         guard++;
      end
      @(negedge clk);
      a_en = 1'b0;
      n_cmp++;
      if (t1.size() < 3 || t15.size() < 3) begin
         n_fail++;
         $display("FAIL spacing_timeout: pulses l1=%0d l15=%0d expected >=3", t1.size(), t15.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (t1[i] - t1[i-1] != 3) begin
               n_fail++;
               $display("FAIL spacing_l1: got %0d expected 3", t1[i] - t1[i-1]);
            end
            n_cmp++;
            if (t15[i] - t15[i-1] != 17) begin
               n_fail++;
               $display("FAIL spacing_l15: got %0d expected 17", t15[i] - t15[i-1]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_lanes();
      test_alias();
      test_misaligned();
      test_back_to_back();
      repeat (3) @(posedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d responses missing expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
